rapids_mem_responder: RTL and testbench

//  Memory-side responder for the rapids core's load/store/fetch port: accepts one

---
 rtl/rapids_mem_responder_pkg.sv | 6 +
 rtl/rapids_mem_responder_if.sv | 25 ++
 rtl/rapids_mem_responder_array.sv | 23 ++
 rtl/rapids_mem_responder.sv | 78 +++++++
 tb/tb_rapids_mem_responder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/rapids_mem_responder_pkg.sv
// rapids_mem_responder_pkg: shared widths and FSM state type for the rapids memory responder
package rapids_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/rapids_mem_responder_if.sv
// rapids_mem_responder_if: request/response channel between the core-side initiator and the responder
interface rapids_mem_responder_if
  import rapids_pkg::*;
#(
  parameter int ADDR_W = 10
);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0] req_be;
  logic rsp_valid;
  logic rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rapids_mem_responder_array.sv
// rapids_mem_array: word storage with byte-enable writes and a registered read port
module rapids_mem_array
  import rapids_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW = 10
) (
  input logic clk,
  input logic we,
  input logic re,
  input logic [AW-1:0] addr,
  input logic [WORD_W-1:0] wdata,
  input logic [BE_W-1:0] be,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] memory [DEPTH];
  // storage is deliberately unreset so preloaded images survive a reset
  always_ff @(posedge clk) begin
    if (re) rdata <= memory[addr];
    for (int i = 0; i < BE_W; i++)
      if (we && be[i]) memory[addr][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: rtl/rapids_mem_responder.sv
// rapids_mem_responder: single-outstanding memory responder with fixed access latency
module rapids_mem_responder
  import rapids_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic reset,
  rapids_mem_responder_if.slave bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_t state;
  logic [3:0] cnt;
  logic lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_wdata;
  logic [BE_W-1:0] lat_be;
  logic rdy, vld, err, rd_ok, hit, acc;
  logic [WORD_W-1:0] arr_rdata;
  assign hit = {1'b0, lat_addr} < (ADDR_W + 1)'(DEPTH);
  assign acc = state == WAIT && cnt == '0;
  assign bus.req_ready = rdy;
  assign bus.rsp_valid = vld;
  assign bus.rsp_err = err;
  assign bus.rsp_rdata = rd_ok ? arr_rdata : '0;
  rapids_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_arr (
    .clk(clk),
    .we(acc && lat_we && hit),
    .re(acc && !lat_we && hit),
    .addr(lat_addr[AW-1:0]),
    .wdata(lat_wdata),
    .be(lat_be),
    .rdata(arr_rdata)
  );
  // accept latches the request; WAIT counts down so the response lands LATENCY edges after accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rdy <= 1'b1;
      vld <= 1'b0;
      err <= 1'b0;
      rd_ok <= 1'b0;
      lat_we <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_be <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          lat_we <= bus.req_we;
          lat_addr <= bus.req_addr;
          lat_wdata <= bus.req_wdata;
          lat_be <= bus.req_be;
          rdy <= 1'b0;
          cnt <= 4'(LATENCY - 1);
          state <= WAIT;
        end
        WAIT: if (acc) begin
          state <= RESP;
          vld <= 1'b1;
          err <= !hit;
          rd_ok <= !lat_we && hit;
        end else cnt <= cnt - 4'd1;
        RESP: if (bus.rsp_ready) begin
          state <= IDLE;
          vld <= 1'b0;
          err <= 1'b0;
          rd_ok <= 1'b0;
          rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rapids_mem_responder.sv
// tb_rapids_mem_responder: directed checks of latency, byte enables, backpressure, range errors and reset
module tb_rapids_mem_responder;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  int vec = 0;
  int errs = 0;
  int sel = 2;
  logic req_valid = 0;
  logic req_we = 0;
  logic rsp_ready = 0;
  logic [10:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic [3:0] req_be = 0;
  logic rr, rv, re_;
  logic [31:0] rd;
  rapids_mem_responder_if #(.ADDR_W(11)) m1 ();
  rapids_mem_responder_if #(.ADDR_W(11)) m2 ();
  rapids_mem_responder_if #(.ADDR_W(11)) m5 ();
  assign m1.req_valid = req_valid && sel == 1;
  assign m2.req_valid = req_valid && sel == 2;
  assign m5.req_valid = req_valid && sel == 5;
  assign m1.rsp_ready = rsp_ready && sel == 1;
  assign m2.rsp_ready = rsp_ready && sel == 2;
  assign m5.rsp_ready = rsp_ready && sel == 5;
  assign m1.req_we = req_we;
  assign m2.req_we = req_we;
  assign m5.req_we = req_we;
  assign m1.req_addr = req_addr;
  assign m2.req_addr = req_addr;
  assign m5.req_addr = req_addr;
  assign m1.req_wdata = req_wdata;
  assign m2.req_wdata = req_wdata;
  assign m5.req_wdata = req_wdata;
  assign m1.req_be = req_be;
  assign m2.req_be = req_be;
  assign m5.req_be = req_be;
  always_comb begin
    rr = sel == 1 ? m1.req_ready : sel == 5 ? m5.req_ready : m2.req_ready;
    rv = sel == 1 ? m1.rsp_valid : sel == 5 ? m5.rsp_valid : m2.rsp_valid;
    re_ = sel == 1 ? m1.rsp_err : sel == 5 ? m5.rsp_err : m2.rsp_err;
    rd = sel == 1 ? m1.rsp_rdata : sel == 5 ? m5.rsp_rdata : m2.rsp_rdata;
  end
  rapids_mem_responder #(.ADDR_W(11), .DEPTH(1024), .LATENCY(1)) d1 (.clk(clk), .reset(rst), .bus(m1));
  rapids_mem_responder #(.ADDR_W(11), .DEPTH(1024), .LATENCY(2)) d2 (.clk(clk), .reset(rst), .bus(m2));
  rapids_mem_responder #(.ADDR_W(11), .DEPTH(1024), .LATENCY(5)) d5 (.clk(clk), .reset(rst), .bus(m5));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [10:0] a, input logic [31:0] d, input logic [3:0] be,
                      output int lat, output logic [31:0] rdata, output logic err);
    req_we = we;
    req_addr = a;
    req_wdata = d;
    req_be = be;
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    while (!rv && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rd;
    err = re_;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    logic [31:0] d;
    logic e;
    d1.u_arr.memory[0] = 32'h9EF10004;
    d2.u_arr.memory[0] = 32'h9EF10004;
    d5.u_arr.memory[0] = 32'h9EF10004;
    d2.u_arr.memory[3] = 32'h0;
    d2.u_arr.memory[64] = 32'h11223344;
    d2.u_arr.memory[1023] = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_req_ready", 32'(rr), 1);
    chk("rst_rsp_valid", 32'(rv), 0);
    chk("rst_rsp_err", 32'(re_), 0);
    chk("rst_rsp_rdata", rd, 0);
    xact(0, 0, 0, 0, lat, d, e);
    chk("lat2_edges", 32'(lat), 2);
    chk("lat2_rdata", d, 32'h9EF10004);
    chk("lat2_err", 32'(e), 0);
    sel = 1;
    xact(0, 0, 0, 4'hF, lat, d, e);
    chk("lat1_edges", 32'(lat), 1);
    chk("lat1_rdata", d, 32'h9EF10004);
    sel = 5;
    xact(0, 0, 0, 4'hF, lat, d, e);
    chk("lat5_edges", 32'(lat), 5);
    chk("lat5_rdata", d, 32'h9EF10004);
    sel = 2;
    xact(1, 64, 32'hAABBCCDD, 4'b0101, lat, d, e);
    chk("be_store_rdata", d, 0);
    chk("be_store_err", 32'(e), 0);
    xact(0, 64, 0, 0, lat, d, e);
    chk("be_load", d, 32'h11BB33DD);
    xact(1, 64, 32'hFFFFFFFF, 4'b0000, lat, d, e);
    chk("be0_err", 32'(e), 0);
    chk("be0_lat", 32'(lat), 2);
    xact(0, 64, 0, 4'hF, lat, d, e);
    chk("be0_unchanged", d, 32'h11BB33DD);
    req_we = 0;
    req_addr = 64;
    req_be = 0;
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    chk("bp_req_ready_busy", 32'(rr), 0);
    n = 0;
    while (!rv && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_lat", 32'(n), 2);
    req_we = 1;
    req_addr = 0;
    req_wdata = 32'hFFFFFFFF;
    req_be = 4'hF;
    req_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(rv), 1);
      chk("bp_rdata", rd, 32'h11BB33DD);
      chk("bp_req_ready", 32'(rr), 0);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("bp_release_valid", 32'(rv), 0);
    chk("bp_release_ready", 32'(rr), 1);
    chk("bp_release_rdata", rd, 0);
    xact(0, 0, 0, 4'hF, lat, d, e);
    chk("bp_ignored_store", d, 32'h9EF10004);
    xact(1, 1023, 32'h5A5A0001, 4'hF, lat, d, e);
    chk("oor_1023_err", 32'(e), 0);
    xact(1, 1024, 32'hDEADBEEF, 4'hF, lat, d, e);
    chk("oor_1024_err", 32'(e), 1);
    chk("oor_1024_rdata", d, 0);
    chk("oor_1024_lat", 32'(lat), 2);
    chk("oor_mem1023", d2.u_arr.memory[1023], 32'h5A5A0001);
    chk("oor_mem0", d2.u_arr.memory[0], 32'h9EF10004);
    xact(0, 1024, 0, 4'hF, lat, d, e);
    chk("oor_load_err", 32'(e), 1);
    chk("oor_load_rdata", d, 0);
    xact(0, 1023, 0, 4'hF, lat, d, e);
    chk("oor_load_1023", d, 32'h5A5A0001);
    req_we = 1;
    req_addr = 3;
    req_wdata = 32'h0000000A;
    req_be = 4'hF;
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    chk("rmid_busy", 32'(rr), 0);
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rv) n++;
    end
    chk("rmid_rsp_valid", 32'(n), 0);
    chk("rmid_mem3", d2.u_arr.memory[3], 0);
    chk("rmid_req_ready", 32'(rr), 1);
    xact(0, 3, 0, 4'hF, lat, d, e);
    chk("rmid_load3", d, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
